// File: rtl/frame_float_sequencer.sv
// Walks the raw-pixel frame RAM and streams each uint16 pixel as an
// IEEE-754 single float over a valid/ready port with a 2-entry buffer.
module frame_float_sequencer #(
  parameter int FRAME_PIXELS = 768,
  parameter int ADDR_WIDTH   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [15:0]           ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_last,
  output logic [ADDR_WIDTH-1:0] out_index
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LP_FRAME = CW'(FRAME_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST =
    ADDR_WIDTH'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]         r_rd_cnt;
  logic                  r_pend;
  logic [ADDR_WIDTH-1:0] r_pend_idx;
  logic [1:0]            r_cnt;
  logic [31:0]           r_h_data;
  logic [ADDR_WIDTH-1:0] r_h_idx;
  logic                  r_h_last;
  logic [31:0]           r_t_data;
  logic [ADDR_WIDTH-1:0] r_t_idx;
  logic                  r_t_last;

  logic                  w_hs;
  logic                  w_issue;
  logic                  w_accept;
  logic                  w_new_last;
  logic [2:0]            w_load;
  logic [31:0]           w_conv;

  // Exact: a 16-bit integer always fits in the 24-bit significand.
  function automatic logic [31:0] f_u16(input logic [15:0] v);
    logic [3:0]  p;
    logic [23:0] s;
    p = '0;
    for (int i = 0; i < 16; i++)
      if (v[i]) p = 4'(i);
    s = {8'b0, v} << (5'd23 - {1'b0, p});
    f_u16 = (v == 16'd0) ? 32'd0 :
      {1'b0, 8'd127 + {4'b0, p}, s[22:0]};
  endfunction

  assign out_valid  = (r_cnt != 2'd0);
  assign out_data   = r_h_data;
  assign out_last   = r_h_last;
  assign out_index  = r_h_idx;
  assign w_hs       = out_valid && out_ready;
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_new_last = (r_pend_idx == LP_LAST);
  assign w_conv     = f_u16(ram_rd_data);

  // Slots claimed after this cycle's handshake frees one.
  assign w_load  = {1'b0, r_cnt} + {2'b0, r_pend} - {2'b0, w_hs};
  assign w_issue = (r_rd_cnt < LP_FRAME) && (w_load < 3'd2);
  assign ram_addr =
    ram_rd_en ? r_rd_cnt[ADDR_WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    ram_rd_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        ram_rd_en = w_issue;
        if (w_hs && r_h_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_cnt   <= '0;
      r_pend     <= 1'b0;
      r_pend_idx <= '0;
    end else begin
      r_pend     <= ram_rd_en;
      r_pend_idx <= r_rd_cnt[ADDR_WIDTH-1:0];
      if (w_accept)       r_rd_cnt <= '0;
      else if (ram_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_h_data <= '0;
      r_h_idx  <= '0;
      r_h_last <= 1'b0;
      r_t_data <= '0;
      r_t_idx  <= '0;
      r_t_last <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else begin
      unique case ({r_pend, w_hs})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_h_data <= w_conv;
            r_h_idx  <= r_pend_idx;
            r_h_last <= w_new_last;
          end else begin
            r_t_data <= w_conv;
            r_t_idx  <= r_pend_idx;
            r_t_last <= w_new_last;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_h_data <= r_t_data;
          r_h_idx  <= r_t_idx;
          r_h_last <= r_t_last;
          r_cnt    <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_h_data <= w_conv;
            r_h_idx  <= r_pend_idx;
            r_h_last <= w_new_last;
          end else begin
            r_h_data <= r_t_data;
            r_h_idx  <= r_t_idx;
            r_h_last <= r_t_last;
            r_t_data <= w_conv;
            r_t_idx  <= r_pend_idx;
            r_t_last <= w_new_last;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (reset)
    !(r_pend && !w_hs && r_cnt == 2'd2));

endmodule

// File: tb/tb_frame_float_sequencer.sv
// Randomized bench for frame_float_sequencer: three frame sizes run
// side by side, each against a count-based model of the stream.
module tb_frame_float_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int f,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL F%0d %s got=%0h exp=%0h t=%0t",
               f, nm, got, exp, $time);
    end
  endtask

  // Float value from plain arithmetic: 2^e * (1 + frac).
  function automatic logic [31:0] ref_f(input int v);
    int     e;
    longint man;
    if (v == 0) return 32'd0;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    man = (longint'(v) - (longint'(1) << e)) << (23 - e);
    return {1'b0, 8'(127 + e), 23'(man)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gb
    localparam int F = (g == 0) ? 3 : (g == 1) ? 1 : 768;

    logic        rst, start, ready;
    logic        busy, done, rd_en, valid, last;
    logic [9:0]  addr, idx;
    logic [15:0] rdata;
    logic [31:0] data;
    logic [15:0] ram [1024];
    logic        fin = 1'b0;
    logic [31:0] log_q [$];

    frame_float_sequencer #(
      .FRAME_PIXELS(F),
      .ADDR_WIDTH(10)
    ) dut (
      .clk(clk),
      .reset(rst),
      .start(start),
      .busy(busy),
      .done(done),
      .ram_rd_en(rd_en),
      .ram_addr(addr),
      .ram_rd_data(rdata),
      .out_valid(valid),
      .out_ready(ready),
      .out_data(data),
      .out_last(last),
      .out_index(idx)
    );

    always @(posedge clk)
      if (rd_en) rdata <= ram[addr];

    int          m_st = 0;
    int          m_rd = 0;
    int          m_idx = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pd = '0;
    logic [9:0]  pi = '0;

    always @(negedge clk) begin
      logic hs;
      logic lexp;
      logic erd;
      if (rst) begin
        chk("rst_busy", F, busy, 0);
        chk("rst_done", F, done, 0);
        chk("rst_rd_en", F, rd_en, 0);
        chk("rst_addr", F, addr, 0);
        chk("rst_valid", F, valid, 0);
        chk("rst_data", F, data, 0);
        chk("rst_last", F, last, 0);
        chk("rst_index", F, idx, 0);
        m_st = 0;
        pv = 1'b0;
      end else begin
        chk("busy", F, busy, m_st == 1);
        chk("done", F, done, m_st == 2);
        if (m_st != 1) begin
          chk("idle_valid", F, valid, 0);
          chk("idle_rd_en", F, rd_en, 0);
          if (m_st == 2) m_st = 0;
          else if (start) begin
            m_st = 1;
            m_rd = 0;
            m_idx = 0;
            log_q.delete();
          end
          pv = 1'b0;
        end else begin
          if (pv && !pr) begin
            chk("hold_valid", F, valid, 1);
            chk("hold_data", F, data, pd);
            chk("hold_index", F, idx, pi);
          end
          if (valid) begin
            chk("index", F, idx, m_idx);
            chk("data", F, data, ref_f(int'(ram[m_idx])));
            chk("last", F, last, m_idx == F - 1);
          end
          hs = valid && ready;
          lexp = (m_idx == F - 1);
          if (hs) begin
            log_q.push_back(data);
            m_idx++;
          end
          erd = (m_rd < F) && (m_rd - m_idx < 2);
          chk("rd_en", F, rd_en, erd);
          if (rd_en) begin
            chk("addr", F, addr, m_rd);
            m_rd++;
          end
          if (hs && lexp) m_st = 2;
          pv = valid;
          pr = ready;
          pd = data;
          pi = idx;
        end
      end
    end

    initial begin
      int k;
      int bp;
      logic seen_v;
      rst = 1'b1;
      start = 1'b0;
      ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      for (int fr = 0; fr < 4; fr++) begin
        for (int i = 0; i < 1024; i++) begin
          ram[i] = 16'($urandom);
          if ($urandom_range(0, 15) == 0) ram[i] = '0;
        end
        if (fr == 0 && F == 3) begin
          ram[0] = 16'd1253;
          ram[1] = 16'd673;
          ram[2] = 16'd47;
        end
        if (fr == 0 && F == 768) begin
          ram[0] = 16'd0;
          ram[1] = 16'd1;
          ram[2] = 16'd65535;
          ram[3] = 16'd32768;
        end
        if (fr == 3 && F >= 8) begin
          start = 1'b1;
          ready = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
          k = 0;
          while (log_q.size() < 5 && k < 100) begin
            @(posedge clk);
            #1 k++;
          end
          chk("pre_reset_outputs", F, log_q.size(), 5);
          #2 rst = 1'b1;
          #1;
          chk("async_valid", F, valid, 0);
          chk("async_rd_en", F, rd_en, 0);
          chk("async_busy", F, busy, 0);
          chk("async_data", F, data, 0);
          chk("async_index", F, idx, 0);
          @(posedge clk);
          #1 rst = 1'b0;
          for (int i = 0; i < 1024; i++)
            ram[i] = 16'($urandom);
          @(posedge clk);
          #1;
        end
        start = 1'b1;
        ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        k = 1;
        bp = 0;
        seen_v = 1'b0;
        while (!done && k < 8 * F + 200) begin
          if (fr == 1 || fr == 3) begin
            if (valid) seen_v = 1'b1;
            if (fr == 1 && seen_v && bp < 10) begin
              ready = 1'b0;
              bp++;
            end else begin
              ready = ($urandom_range(0, 3) != 0);
            end
            start = ($urandom_range(0, 7) == 0);
          end
          @(posedge clk);
          #1 k++;
        end
        chk("done_seen", F, done, 1);
        if (fr == 0 || fr == 2)
          chk("latency", F, k, F + 3);
        chk("frame_len", F, log_q.size(), F);
        if (fr == 0 && F == 3) begin
          chk("lit0", F, log_q[0], 32'h449CA000);
          chk("lit1", F, log_q[1], 32'h44284000);
          chk("lit2", F, log_q[2], 32'h423C0000);
        end
        if (fr == 0 && F == 768) begin
          chk("edge0", F, log_q[0], 32'h00000000);
          chk("edge1", F, log_q[1], 32'h3F800000);
          chk("edge65535", F, log_q[2], 32'h477FFF00);
          chk("edge32768", F, log_q[3], 32'h47000000);
        end
        start = (fr == 1);
        ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1 fin = 1'b1;
    end
  end

  initial begin
    int c;
    chk("model_0", 0, ref_f(0), 32'h00000000);
    chk("model_1", 0, ref_f(1), 32'h3F800000);
    chk("model_65535", 0, ref_f(65535), 32'h477FFF00);
    chk("model_32768", 0, ref_f(32768), 32'h47000000);
    chk("model_1253", 0, ref_f(1253), 32'h449CA000);
    chk("model_673", 0, ref_f(673), 32'h44284000);
    chk("model_47", 0, ref_f(47), 32'h423C0000);
    c = 0;
    while (!(gb[0].fin && gb[1].fin && gb[2].fin)
           && c < 60000) begin
      @(posedge clk);
      c++;
    end
    chk("bench_complete", 0,
        {gb[0].fin, gb[1].fin, gb[2].fin}, 3'b111);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
